// File: rtl/plab5_mcore_mem_req_ctrl_guard.sv
// plab5_mcore_mem_req_ctrl_guard
//   Two-entry in-order buffer for unpacked memory request control messages
//   {type, opaque, addr, len}. Requests from the normal domain (domain=0)
//   that touch any byte of [p_sec_base, p_sec_bound) are steered to the deny
//   channel; everything else is forwarded unchanged on the out channel.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_domain, in_msg, in_val/in_rdy  request input
//   out_msg, out_domain, out_val/rdy  forwarded request
//   deny_type, deny_opaque, deny_val/rdy  denied request summary
//   deny_count                        saturating count of denied requests
module plab5_mcore_mem_req_ctrl_guard #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter logic [p_addr_nbits-1:0] p_sec_base  = 'h0000_8000,
  parameter logic [p_addr_nbits-1:0] p_sec_bound = 'h0000_9000,
  parameter int p_cnt_nbits    = 16,
  localparam int lp_len_nbits  = $clog2(p_data_nbits/8),
  localparam int lp_msg_nbits  = 3 + p_opaque_nbits + p_addr_nbits + lp_len_nbits
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_domain,
  input  logic [lp_msg_nbits-1:0]   in_msg,
  input  logic                      in_val,
  output logic                      in_rdy,
  output logic [lp_msg_nbits-1:0]   out_msg,
  output logic                      out_domain,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [2:0]                deny_type,
  output logic [p_opaque_nbits-1:0] deny_opaque,
  output logic                      deny_val,
  input  logic                      deny_rdy,
  output logic [p_cnt_nbits-1:0]    deny_count
);

  localparam int a = p_addr_nbits;
  localparam int l = lp_len_nbits;
  localparam int o = p_opaque_nbits;
  localparam int c = lp_msg_nbits;

  // FIFO storage: entry = {domain, msg}
  logic [c:0] mem [2];
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;

  logic [c:0] head;
  logic       empty, full;
  logic       enq, deq, deny_fire;

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

  // Head field extraction
  logic           h_dom;
  logic [2:0]     h_type;
  logic [o-1:0]   h_opaque;
  logic [a-1:0]   h_addr;
  logic [l-1:0]   h_len;

  assign h_dom    = head[c];
  assign h_type   = head[c-1 -: 3];
  assign h_opaque = head[l+a +: o];
  assign h_addr   = head[l +: a];
  assign h_len    = head[l-1:0];

  // Byte range touched by the head; one extra bit so addr+span-1 cannot wrap.
  logic [a:0] span, lo, hi;
  logic       viol;

  assign span = (h_len == '0) ? (a+1)'(p_data_nbits/8) : {{(a+1-l){1'b0}}, h_len};
  assign lo   = {1'b0, h_addr};
  assign hi   = lo + span - (a+1)'(1);
  assign viol = !h_dom && (hi >= {1'b0, p_sec_base}) && (lo < {1'b0, p_sec_bound});

  // Payloads forced to zero when empty so nothing stale leaks out.
  assign out_val     = !empty && !viol;
  assign deny_val    = !empty &&  viol;
  assign out_msg     = empty ? '0   : head[c-1:0];
  assign out_domain  = empty ? 1'b0 : h_dom;
  assign deny_type   = empty ? '0   : h_type;
  assign deny_opaque = empty ? '0   : h_opaque;

  // Full blocks input even if the head leaves this cycle (no pass-through).
  assign in_rdy    = !reset && !full;
  assign enq       = in_val && in_rdy;
  assign deny_fire = !reset && deny_val && deny_rdy;
  assign deq       = (!reset && out_val && out_rdy) || deny_fire;

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {in_domain, in_msg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      deny_count <= '0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, enq} - {1'b0, deq};
      if (deny_fire && (deny_count != '1))
        deny_count <= deny_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_ctrl_guard.sv
// Self-checking bench: directed scenarios plus a randomized run compared
// against a queue-based model of the guard's rules.
module tb_plab5_mcore_mem_req_ctrl_guard;

  localparam int CW = 2;        // narrow counter so saturation is reachable
  localparam int MW = 45;       // 3 + 8 + 32 + 2
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_domain;
  logic [MW-1:0] in_msg;
  logic          in_val, in_rdy;
  logic [MW-1:0] out_msg;
  logic          out_domain, out_val, out_rdy;
  logic [2:0]    deny_type;
  logic [7:0]    deny_opaque;
  logic          deny_val, deny_rdy;
  logic [CW-1:0] deny_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [MW:0]   mq[$];
  logic [CW-1:0] mcnt;

  always #5 clk = ~clk;

  plab5_mcore_mem_req_ctrl_guard #(.p_cnt_nbits(CW)) dut (
    .clk(clk), .reset(reset),
    .in_domain(in_domain), .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
    .out_msg(out_msg), .out_domain(out_domain), .out_val(out_val), .out_rdy(out_rdy),
    .deny_type(deny_type), .deny_opaque(deny_opaque), .deny_val(deny_val),
    .deny_rdy(deny_rdy), .deny_count(deny_count)
  );

  function automatic logic [MW-1:0] mk(logic [2:0] t, logic [7:0] op, logic [31:0] ad, logic [1:0] ln);
    return {t, op, ad, ln};
  endfunction

  // Does a normal-domain request overlap any byte of [0x8000, 0x9000)?
  function automatic bit denied(logic [MW:0] e);
    longint lo, n, hi;
    lo = longint'(e[33:2]);
    n  = (e[1:0] == 2'd0) ? 4 : longint'(e[1:0]);
    hi = lo + n - 1;
    return (e[MW] == 1'b0) && (hi >= 64'h8000) && (lo < 64'h9000);
  endfunction

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    int sz;
    sz = mq.size();
    if (reset) begin
      mq.delete();
      mcnt = '0;
    end else begin
      if (sz > 0) begin
        if (denied(mq[0])) begin
          if (deny_rdy) begin
            void'(mq.pop_front());
            if (mcnt != CMAX) mcnt = mcnt + 1'b1;
          end
        end else if (out_rdy) begin
          void'(mq.pop_front());
        end
      end
      if (in_val && sz < 2) mq.push_back({in_domain, in_msg});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic d, logic [MW-1:0] m);
    in_domain = d; in_msg = m; in_val = 1'b1;
    tick();
    in_val = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_val = 1'b0; in_domain = 1'b0; in_msg = '0;
    out_rdy = 1'b1; deny_rdy = 1'b1;
    tick();
    tick();
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_in_rdy_during got=%b want=0", in_rdy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL rst_out_val got=%b want=0", out_val); end
    n_cmp++; if (deny_val !== 1'b0) begin n_bad++; $display("FAIL rst_deny_val got=%b want=0", deny_val); end
    n_cmp++; if (deny_count !== '0) begin n_bad++; $display("FAIL rst_deny_count got=%0d want=0", deny_count); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_in_rdy_after got=%b want=1", in_rdy); end
  endtask

  task automatic test_forward();
    logic [MW-1:0] m;
    m = mk(3'd0, 8'h5A, 32'h8004, 2'd0);
    send(1'b1, m);
    n_cmp++; if (out_val !== 1'b1) begin n_bad++; $display("FAIL fwd_out_val got=%b want=1", out_val); end
    n_cmp++; if (out_msg !== m) begin n_bad++; $display("FAIL fwd_out_msg got=%h want=%h", out_msg, m); end
    n_cmp++; if (out_domain !== 1'b1) begin n_bad++; $display("FAIL fwd_out_domain got=%b want=1", out_domain); end
    n_cmp++; if (deny_val !== 1'b0) begin n_bad++; $display("FAIL fwd_deny_val got=%b want=0", deny_val); end
    tick();
  endtask

  task automatic test_deny();
    send(1'b0, mk(3'd1, 8'h11, 32'h8FFC, 2'd0));
    n_cmp++; if (deny_val !== 1'b1) begin n_bad++; $display("FAIL deny_val got=%b want=1", deny_val); end
    n_cmp++; if (deny_type !== 3'd1) begin n_bad++; $display("FAIL deny_type got=%0d want=1", deny_type); end
    n_cmp++; if (deny_opaque !== 8'h11) begin n_bad++; $display("FAIL deny_opaque got=%h want=11", deny_opaque); end
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL deny_out_val got=%b want=0", out_val); end
    tick();
    n_cmp++; if (deny_count !== 2'd1) begin n_bad++; $display("FAIL deny_count got=%0d want=1", deny_count); end
  endtask

  task automatic test_window_edges();
    logic [31:0] ad [4] = '{32'h7FFE, 32'h7FFC, 32'h9000, 32'h7FFF};
    logic [1:0]  ln [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    bit          dn [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(1'b0, mk(3'd0, 8'(i), ad[i], ln[i]));
      n_cmp++; if (deny_val !== dn[i]) begin n_bad++; $display("FAIL edge%0d_deny_val addr=%h got=%b want=%b", i, ad[i], deny_val, dn[i]); end
      n_cmp++; if (out_val !== !dn[i]) begin n_bad++; $display("FAIL edge%0d_out_val addr=%h got=%b want=%b", i, ad[i], out_val, !dn[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] a, b, cc, d, e;
    a  = mk(3'd0, 8'hA0, 32'h1000, 2'd0);
    b  = mk(3'd1, 8'hB0, 32'h2000, 2'd2);
    cc = mk(3'd2, 8'hC0, 32'h3000, 2'd3);
    out_rdy = 1'b0;
    in_domain = 1'b0; in_val = 1'b1;
    in_msg = a; tick();
    n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL bp_rdy_after_a got=%b want=1", in_rdy); end
    in_msg = b; tick();
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL bp_rdy_full got=%b want=0", in_rdy); end
    in_msg = cc; tick();
    n_cmp++; if (out_msg !== a) begin n_bad++; $display("FAIL bp_head_a got=%h want=%h", out_msg, a); end
    out_rdy = 1'b1; tick();   // A leaves; C refused since FIFO was full
    n_cmp++; if (out_msg !== b) begin n_bad++; $display("FAIL bp_head_b got=%h want=%h", out_msg, b); end
    tick();                   // B leaves, C enters
    in_val = 1'b0;
    n_cmp++; if (out_msg !== cc) begin n_bad++; $display("FAIL bp_head_c got=%h want=%h", out_msg, cc); end
    tick();
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL bp_drained got=%b want=0", out_val); end

    // Denied head stalls an allowed entry behind it.
    d = mk(3'd1, 8'hD0, 32'h8800, 2'd0);
    e = mk(3'd0, 8'hE0, 32'h0040, 2'd0);
    deny_rdy = 1'b0;
    send(1'b0, d);
    send(1'b0, e);
    tick(); tick();
    n_cmp++; if (deny_val !== 1'b1 || deny_opaque !== 8'hD0) begin n_bad++; $display("FAIL bp2_deny_hold got=%b/%h want=1/d0", deny_val, deny_opaque); end
    n_cmp++; if (out_val !== 1'b0) begin n_bad++; $display("FAIL bp2_out_blocked got=%b want=0", out_val); end
    deny_rdy = 1'b1; tick();
    n_cmp++; if (out_val !== 1'b1 || out_msg !== e) begin n_bad++; $display("FAIL bp2_e_after got=%b/%h want=1/%h", out_val, out_msg, e); end
    tick();
  endtask

  task automatic test_saturate_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    in_domain = 1'b0; in_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_msg = mk(3'd0, 8'(i), 32'h8100 + 32'(i), 2'd0);
      tick();
    end
    in_val = 1'b0;
    tick(); tick();
    n_cmp++; if (deny_count !== 2'd3) begin n_bad++; $display("FAIL sat_count got=%0d want=3", deny_count); end
    out_rdy = 1'b0;
    send(1'b1, mk(3'd0, 8'h01, 32'h0100, 2'd0));
    send(1'b1, mk(3'd0, 8'h02, 32'h0200, 2'd0));
    n_cmp++; if (in_rdy !== 1'b0) begin n_bad++; $display("FAIL rst2_full got=%b want=0", in_rdy); end
    reset = 1'b1; in_val = 1'b1; tick();   // offered input must not be taken
    reset = 1'b0; in_val = 1'b0; out_rdy = 1'b1; #1;
    n_cmp++; if (out_val !== 1'b0 || deny_val !== 1'b0) begin n_bad++; $display("FAIL rst2_empty got=%b/%b want=0/0", out_val, deny_val); end
    n_cmp++; if (deny_count !== 2'd0) begin n_bad++; $display("FAIL rst2_count got=%0d want=0", deny_count); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_bad++; $display("FAIL rst2_in_rdy got=%b want=1", in_rdy); end
    tick(); tick();
    n_cmp++; if (out_val !== 1'b0 || deny_val !== 1'b0) begin n_bad++; $display("FAIL rst2_stale got=%b/%b want=0/0", out_val, deny_val); end
  endtask

  task automatic test_random();
    logic [31:0] ad;
    logic        ev, dv;
    for (int cyc = 0; cyc < 600; cyc++) begin
      // Compare against the model.
      ev = (mq.size() > 0) && !denied(mq[0]);
      dv = (mq.size() > 0) &&  denied(mq[0]);
      n_cmp++; if (in_rdy !== (!reset && mq.size() < 2)) begin n_bad++; $display("FAIL rnd_in_rdy cyc=%0d got=%b want=%b", cyc, in_rdy, !reset && mq.size() < 2); end
      n_cmp++; if (out_val !== ev) begin n_bad++; $display("FAIL rnd_out_val cyc=%0d got=%b want=%b", cyc, out_val, ev); end
      n_cmp++; if (deny_val !== dv) begin n_bad++; $display("FAIL rnd_deny_val cyc=%0d got=%b want=%b", cyc, deny_val, dv); end
      n_cmp++; if (deny_count !== mcnt) begin n_bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, deny_count, mcnt); end
      if (ev) begin
        n_cmp++; if (out_msg !== mq[0][MW-1:0] || out_domain !== mq[0][MW]) begin n_bad++; $display("FAIL rnd_out_payload cyc=%0d got=%b:%h want=%b:%h", cyc, out_domain, out_msg, mq[0][MW], mq[0][MW-1:0]); end
      end
      if (dv) begin
        n_cmp++; if (deny_type !== mq[0][44:42] || deny_opaque !== mq[0][41:34]) begin n_bad++; $display("FAIL rnd_deny_payload cyc=%0d got=%0d:%h want=%0d:%h", cyc, deny_type, deny_opaque, mq[0][44:42], mq[0][41:34]); end
      end
      if (mq.size() == 0) begin
        n_cmp++; if (out_msg !== '0 || deny_opaque !== '0) begin n_bad++; $display("FAIL rnd_empty_zero cyc=%0d got=%h/%h want=0/0", cyc, out_msg, deny_opaque); end
      end
      // New stimulus.
      case ($urandom_range(0, 2))
        0:       ad = 32'h7FF8 + $urandom_range(0, 16);
        1:       ad = 32'h8FF8 + $urandom_range(0, 16);
        default: ad = $urandom;
      endcase
      reset     = ($urandom_range(0, 59) == 0);
      in_val    = ($urandom_range(0, 3) != 0);
      in_domain = $urandom_range(0, 1);
      in_msg    = mk(3'($urandom_range(0, 7)), 8'($urandom), ad, 2'($urandom_range(0, 3)));
      out_rdy   = ($urandom_range(0, 3) != 0);
      deny_rdy  = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0; in_val = 1'b0;
  endtask

  initial begin
    mcnt = '0;
    test_reset();
    test_forward();
    test_deny();
    test_window_edges();
    test_backpressure();
    test_saturate_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
